// File: rtl/hs_tx_feeder_pkg.sv
// rtl/hs_tx_feeder_pkg.sv - shared defaults and FSM encoding for the TX handshake stages
package hs_tx_feeder_pkg;

    localparam int HS_WIDTH       = 4;
    localparam int HS_DEPTH       = 8;
    localparam int HS_ACK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_WAIT_RISE = 2'd1,
        HS_WAIT_FALL = 2'd2
    } hs_state_e;

endpackage

// File: rtl/hs_tx_feeder_sync_fifo.sv
// rtl/hs_tx_feeder_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and same-cycle pop/push
module sync_fifo
    import hs_tx_feeder_pkg::*;
#(
    parameter int WIDTH = HS_WIDTH,
    parameter int DEPTH = HS_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_pop;
    logic             do_push;

    // The extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign dropped = wr_en && full && !do_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/hs_tx_feeder.sv
// rtl/hs_tx_feeder.sv - feeds buffered words one at a time into a req/busy TX handshake stage
module hs_tx_feeder
    import hs_tx_feeder_pkg::*;
#(
    parameter int WIDTH       = HS_WIDTH,
    parameter int DEPTH       = HS_DEPTH,
    parameter int ACK_TIMEOUT = HS_ACK_TIMEOUT
) (
    input  logic                     clk_tx,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     hs_busy,
    output logic                     data_en,
    output logic [WIDTH-1:0]         data_in,
    output logic                     overflow,
    output logic                     ack_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    hs_state_e        state;
    hs_state_e        state_nx;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nx;
    logic             issue;
    logic             timeout_hit;
    logic [WIDTH-1:0] head;
    logic             drop;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_tx),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .dropped (drop)
    );

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        issue       = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            HS_IDLE: begin
                // A busy still high from the previous transfer blocks the next issue.
                if (!empty && !hs_busy) begin
                    issue    = 1'b1;
                    cnt_nx   = '0;
                    state_nx = HS_WAIT_RISE;
                end
            end
            HS_WAIT_RISE: begin
                if (hs_busy) begin
                    cnt_nx   = '0;
                    state_nx = HS_WAIT_FALL;
                end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    cnt_nx      = '0;
                    state_nx    = HS_IDLE;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HS_WAIT_FALL: begin
                if (!hs_busy) state_nx = HS_IDLE;
            end
            default: state_nx = HS_IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HS_IDLE;
            cnt      <= '0;
            data_en  <= 1'b0;
            data_in  <= '0;
            overflow <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            data_en <= issue;
            if (issue)       data_in  <= head;
            if (drop)        overflow <= 1'b1;
            if (timeout_hit) ack_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hs_tx_feeder.sv
// tb/tb_hs_tx_feeder.sv - directed vector bench for hs_tx_feeder
module tb_hs_tx_feeder;

    logic       clk_tx = 1'b0;
    logic       rst_n;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic       hs_busy = 1'b0;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       data_en;
    logic [3:0] data_in;
    logic       overflow;
    logic       ack_err;

    int   checks = 0;
    int   errors = 0;
    int   issues = 0;
    logic prev_de = 1'b0;

    hs_tx_feeder dut (
        .clk_tx   (clk_tx),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .hs_busy  (hs_busy),
        .data_en  (data_en),
        .data_in  (data_in),
        .overflow (overflow),
        .ack_err  (ack_err)
    );

    always #5 clk_tx = ~clk_tx;

    typedef struct {
        logic       wr;
        logic [3:0] wd;
        logic       busy;
        logic       de;
        logic [3:0] di;
        logic [3:0] lvl;
        logic       emp;
        logic       ful;
    } vec_t;

    vec_t tbl [12];

    always @(negedge clk_tx) begin
        if (data_en === 1'b1) begin
            issues++;
            checks++;
            if (prev_de === 1'b1) begin
                errors++;
                $display("FAIL data_en_width: data_en high 2+ consecutive cycles, required 1");
            end
        end
        prev_de = data_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_tx);
        #1;
    endtask

    task automatic wait_issue(input logic [3:0] exp, input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (data_en === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("issue_seen", {31'd0, found}, 32'd1);
        if (found) chk("issue_data", {28'd0, data_in}, {28'd0, exp});
    endtask

    task automatic finish_hs(input int rise, input int high);
        hs_busy = 1'b0;
        repeat (rise) tick();
        hs_busy = 1'b1;
        repeat (high) tick();
        hs_busy = 1'b0;
    endtask

    initial begin
        int n;

        //            wr    wd     busy  de    di     lvl    emp   ful
        tbl[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 4'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hA, 4'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 4'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 4'd0, 1'b1, 1'b0};
        for (int i = 4; i < 10; i++)
            tbl[i] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'hA, 4'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 4'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'hA, 4'd0, 1'b1, 1'b0};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_empty",    {31'd0, empty},    32'd1);
        chk("rst_full",     {31'd0, full},     32'd0);
        chk("rst_level",    {28'd0, level},    32'd0);
        chk("rst_data_en",  {31'd0, data_en},  32'd0);
        chk("rst_data_in",  {28'd0, data_in},  32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_ack_err",  {31'd0, ack_err},  32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single word via table
        n = issues;
        for (int i = 0; i < 12; i++) begin
            wr_en   = tbl[i].wr;
            wr_data = tbl[i].wd;
            hs_busy = tbl[i].busy;
            tick();
            chk($sformatf("row%0d_data_en", i), {31'd0, data_en}, {31'd0, tbl[i].de});
            chk($sformatf("row%0d_data_in", i), {28'd0, data_in}, {28'd0, tbl[i].di});
            chk($sformatf("row%0d_level", i),   {28'd0, level},   {28'd0, tbl[i].lvl});
            chk($sformatf("row%0d_empty", i),   {31'd0, empty},   {31'd0, tbl[i].emp});
            chk($sformatf("row%0d_full", i),    {31'd0, full},    {31'd0, tbl[i].ful});
        end
        chk("single_issue_count", issues - n, 32'd1);

        // burst: stale busy holds issue off so the FIFO fills
        hs_busy = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_en   = 1'b1;
            wr_data = 4'(i);
            tick();
            chk($sformatf("burst_level%0d", i), {28'd0, level}, i);
            chk($sformatf("burst_full%0d", i), {31'd0, full}, (i == 8) ? 32'd1 : 32'd0);
            chk($sformatf("burst_no_issue%0d", i), {31'd0, data_en}, 32'd0);
        end
        wr_en = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            hs_busy = 1'b0;
            wait_issue(4'(k), 4);
            finish_hs(2, 3);
        end
        tick();
        tick();
        chk("burst_empty_end", {31'd0, empty}, 32'd1);

        // overflow
        hs_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wr_en   = 1'b1;
            wr_data = 4'(i + 1);
            tick();
            if (i == 7) chk("ovf_before_9th", {31'd0, overflow}, 32'd0);
        end
        wr_en = 1'b0;
        chk("ovf_flag",  {31'd0, overflow}, 32'd1);
        chk("ovf_level", {28'd0, level},    32'd8);
        chk("ovf_full",  {31'd0, full},     32'd1);

        // simultaneous pop and write on a full FIFO
        hs_busy = 1'b0;
        wr_en   = 1'b1;
        wr_data = 4'hF;
        tick();
        wr_en = 1'b0;
        chk("sim_data_en", {31'd0, data_en}, 32'd1);
        chk("sim_data_in", {28'd0, data_in}, 32'd1);
        chk("sim_level",   {28'd0, level},   32'd8);
        chk("sim_full",    {31'd0, full},    32'd1);
        finish_hs(2, 3);
        for (int k = 2; k <= 8; k++) begin
            wait_issue(4'(k), 4);
            finish_hs(2, 3);
        end
        wait_issue(4'hF, 4);
        finish_hs(2, 3);
        tick();
        tick();
        chk("sim_empty_end", {31'd0, empty},    32'd1);
        chk("sim_ovf_stick", {31'd0, overflow}, 32'd1);

        // ack timeout
        wr_en   = 1'b1;
        wr_data = 4'h3;
        tick();
        wr_data = 4'h5;
        tick();
        wr_en = 1'b0;
        chk("to_latency_de", {31'd0, data_en}, 32'd1);
        chk("to_latency_di", {28'd0, data_in}, 32'd3);
        repeat (63) tick();
        chk("to_ack_err_63", {31'd0, ack_err}, 32'd0);
        tick();
        chk("to_ack_err_64", {31'd0, ack_err}, 32'd1);
        chk("to_level",      {28'd0, level},   32'd1);
        tick();
        chk("to_next_de", {31'd0, data_en}, 32'd1);
        chk("to_next_di", {28'd0, data_in}, 32'd5);
        finish_hs(2, 3);
        tick();
        chk("to_ack_stick", {31'd0, ack_err}, 32'd1);

        // reset while waiting for busy to fall
        wr_en   = 1'b1;
        wr_data = 4'h6;
        tick();
        wr_data = 4'h7;
        tick();
        wr_en = 1'b0;
        chk("rwf_issue_di", {28'd0, data_in}, 32'd6);
        tick();
        hs_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rwf_data_en",  {31'd0, data_en},  32'd0);
        chk("rwf_data_in",  {28'd0, data_in},  32'd0);
        chk("rwf_level",    {28'd0, level},    32'd0);
        chk("rwf_empty",    {31'd0, empty},    32'd1);
        chk("rwf_full",     {31'd0, full},     32'd0);
        chk("rwf_overflow", {31'd0, overflow}, 32'd0);
        chk("rwf_ack_err",  {31'd0, ack_err},  32'd0);
        n = issues;
        tick();
        hs_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        chk("rwf_no_issue", issues - n, 32'd0);
        wr_en   = 1'b1;
        wr_data = 4'h9;
        tick();
        wr_en = 1'b0;
        tick();
        chk("rwf_new_de", {31'd0, data_en}, 32'd1);
        chk("rwf_new_di", {28'd0, data_in}, 32'd9);
        finish_hs(2, 3);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
